// File: rtl/limb_pkg.sv
// Shared sizes, state encoding and limb/word types for the limb carry normalizer.
package limb_pkg;

    localparam int DEF_NUM_ELEMENTS = 17;
    localparam int DEF_BIT_LEN      = 17;
    localparam int DEF_WORD_LEN     = 16;

    localparam int NUM_LIMBS = 2 * DEF_NUM_ELEMENTS;
    localparam int CARRY_W   = DEF_BIT_LEN - DEF_WORD_LEN + 1;
    localparam int IDX_W     = $clog2(NUM_LIMBS);

    typedef enum logic {
        IDLE,
        RUN
    } norm_state_t;

    typedef logic [DEF_BIT_LEN-1:0]  limb_t;
    typedef logic [DEF_WORD_LEN-1:0] word_t;

endpackage

// File: rtl/carry_step.sv
// One carry-propagation step: adds an incoming carry to a redundant limb and splits
// the result into a canonical word and the carry for the next limb.
module carry_step #(
    parameter  int BIT_LEN  = 17,
    parameter  int WORD_LEN = 16,
    localparam int CARRY_W  = BIT_LEN - WORD_LEN + 1
) (
    input  logic [BIT_LEN-1:0]  limb_i,
    input  logic [CARRY_W-1:0]  carry_i,
    output logic [WORD_LEN-1:0] word_o,
    output logic [CARRY_W-1:0]  carry_o
);

    // One extra bit is enough: max limb plus max carry stays below 2^(BIT_LEN+1).
    logic [BIT_LEN:0] sum;

    assign sum     = {1'b0, limb_i} + {{(BIT_LEN + 1 - CARRY_W){1'b0}}, carry_i};
    assign word_o  = sum[WORD_LEN-1:0];
    assign carry_o = sum[BIT_LEN:WORD_LEN];

endmodule

// File: rtl/limb_carry_normalizer.sv
// Captures a full set of redundant product limbs and streams canonical words LSW first,
// rippling the carry one limb per accepted output beat.
module limb_carry_normalizer
    import limb_pkg::*;
#(
    parameter  int NUM_ELEMENTS = DEF_NUM_ELEMENTS,
    parameter  int BIT_LEN      = DEF_BIT_LEN,
    parameter  int WORD_LEN     = DEF_WORD_LEN,
    localparam int N_LIMBS      = 2 * NUM_ELEMENTS,
    localparam int C_W          = BIT_LEN - WORD_LEN + 1,
    localparam int I_W          = $clog2(N_LIMBS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BIT_LEN-1:0]  in_limbs [N_LIMBS],
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WORD_LEN-1:0] out_word,
    output logic [I_W-1:0]      out_idx,
    output logic                out_last,
    output logic [C_W-1:0]      out_carry,
    output logic                busy
);

    norm_state_t          state_q;
    logic [I_W-1:0]       idx_q;
    logic [I_W-1:0]       idx_d;
    logic [C_W-1:0]       carry_q;
    logic [C_W-1:0]       carry_d;
    logic [BIT_LEN-1:0]   limbs_q [N_LIMBS];
    logic [WORD_LEN-1:0]  word_d;
    logic                 running;
    logic                 last_beat;

    carry_step #(
        .BIT_LEN  (BIT_LEN),
        .WORD_LEN (WORD_LEN)
    ) u_carry_step (
        .limb_i  (limbs_q[idx_q]),
        .carry_i (carry_q),
        .word_o  (word_d),
        .carry_o (carry_d)
    );

    assign running   = (state_q == RUN);
    assign last_beat = (idx_q == I_W'(N_LIMBS - 1));
    assign idx_d     = idx_q + I_W'(1);

    // The limb snapshot is only loaded in IDLE, so in_limbs may change freely during RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= '0;
            limbs_q <= '{default: '0};
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        limbs_q <= in_limbs;
                        idx_q   <= '0;
                        carry_q <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (out_ready) begin
                        if (last_beat) begin
                            idx_q   <= '0;
                            carry_q <= '0;
                            state_q <= IDLE;
                        end else begin
                            idx_q   <= idx_d;
                            carry_q <= carry_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs decode only registered state, so they hold steady while the sink stalls.
    assign in_ready  = !running;
    assign busy      = running;
    assign out_valid = running;
    assign out_idx   = idx_q;
    assign out_word  = running ? word_d : '0;
    assign out_last  = running && last_beat;
    assign out_carry = (running && last_beat) ? carry_d : '0;

endmodule

// File: tb/tb_limb_carry_normalizer.sv
// Scoreboard bench for limb_carry_normalizer: expected beats are queued at stimulus time
// and checked by a monitor on every output handshake.
module tb_limb_carry_normalizer;
    import limb_pkg::*;

    localparam int WL = DEF_WORD_LEN;
    localparam int PW = NUM_LIMBS * WL;

    typedef struct packed {
        word_t              word;
        logic [IDX_W-1:0]   idx;
        logic               last;
        logic [CARRY_W-1:0] carry;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               out_ready = 1'b0;
    limb_t              stim [NUM_LIMBS];
    logic               in_ready;
    logic               out_valid;
    word_t              out_word;
    logic [IDX_W-1:0]   out_idx;
    logic               out_last;
    logic [CARRY_W-1:0] out_carry;
    logic               busy;

    int total = 0;
    int bad   = 0;
    int beats = 0;
    exp_t q[$];
    logic [PW-1:0] acc;

    always #5 clk = ~clk;

    limb_carry_normalizer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_limbs  (stim),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_carry (out_carry),
        .busy      (busy)
    );

    // Reference: the numeric value of the limb vector, sliced into words.
    task automatic push_model();
        logic [559:0] v;
        exp_t e;
        v = '0;
        for (int i = 0; i < NUM_LIMBS; i++) v = v + (560'(stim[i]) << (WL * i));
        for (int i = 0; i < NUM_LIMBS; i++) begin
            e.word  = v[i*WL +: WL];
            e.idx   = IDX_W'(i);
            e.last  = (i == NUM_LIMBS - 1);
            e.carry = v[PW +: CARRY_W];
            q.push_back(e);
        end
    endtask

    task automatic accept_product(output bit to);
        int n;
        to = 1'b0;
        n  = 0;
        @(posedge clk); #1;
        while (!in_ready && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            to = 1'b1;
            return;
        end
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max, output bit to);
        int n;
        n = 0;
        while ((busy || q.size() != 0) && n < max) begin
            @(negedge clk);
            n++;
        end
        to = busy || (q.size() != 0);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                beats++;
                if (out_idx < NUM_LIMBS) acc[int'(out_idx)*WL +: WL] = out_word;
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_beat idx=%0d word=%h required=no beat", out_idx, out_word);
                end else begin
                    e = q.pop_front();
                    total++;
                    if (out_word !== e.word) begin
                        bad++;
                        $display("FAIL word idx=%0d actual=%h required=%h", e.idx, out_word, e.word);
                    end
                    total++;
                    if (out_idx !== e.idx) begin
                        bad++;
                        $display("FAIL idx actual=%0d required=%0d", out_idx, e.idx);
                    end
                    total++;
                    if (out_last !== e.last) begin
                        bad++;
                        $display("FAIL last idx=%0d actual=%b required=%b", e.idx, out_last, e.last);
                    end
                    if (e.last) begin
                        total++;
                        if (out_carry !== e.carry) begin
                            bad++;
                            $display("FAIL carry actual=%0d required=%0d", out_carry, e.carry);
                        end
                    end
                end
            end else if (rst_n && !out_valid) begin
                total++;
                if ({out_word, out_last, out_carry} !== '0) begin
                    bad++;
                    $display("FAIL gating word=%h last=%b carry=%0d required=0", out_word, out_last, out_carry);
                end
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < NUM_LIMBS; i++) stim[i] = '0;
        rst_n = 1'b0;
        #2;
        total++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            bad++;
            $display("FAIL reset_ctrl in_ready/out_valid/busy actual=%b required=100", {in_ready, out_valid, busy});
        end
        total++;
        if ({out_word, out_idx, out_last, out_carry} !== '0) begin
            bad++;
            $display("FAIL reset_data word=%h idx=%0d last=%b carry=%0d required=0", out_word, out_idx, out_last, out_carry);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release in_ready=%b busy=%b required=1,0", in_ready, busy);
        end
    endtask

    task automatic test_all_ones();
        bit to;
        int busy_cycles;
        for (int i = 0; i < NUM_LIMBS; i++) stim[i] = 17'h0FFFF;
        out_ready = 1'b1;
        push_model();
        accept_product(to);
        total++;
        if (to) begin bad++; $display("FAIL accept_ones actual=timeout required=accepted"); end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || out_idx !== '0) begin
            bad++;
            $display("FAIL latency out_valid=%b idx=%0d required=1,0", out_valid, out_idx);
        end
        busy_cycles = 1;
        while (busy && busy_cycles < 200) begin
            @(negedge clk);
            if (busy) busy_cycles++;
        end
        total++;
        if (busy_cycles !== NUM_LIMBS) begin
            bad++;
            $display("FAIL throughput busy_cycles actual=%0d required=%0d", busy_cycles, NUM_LIMBS);
        end
        total++;
        if (q.size() != 0) begin bad++; $display("FAIL ones_leftover actual=%0d required=0", q.size()); end
    endtask

    task automatic test_spill_lsw();
        bit to;
        stim[0] = 17'h1FFFF;
        for (int i = 1; i < NUM_LIMBS; i++) stim[i] = 17'h0FFFF;
        out_ready = 1'b1;
        push_model();
        accept_product(to);
        if (!to) wait_idle(200, to);
        total++;
        if (to) begin bad++; $display("FAIL spill_lsw_done actual=timeout required=drained"); end
    endtask

    task automatic test_all_max();
        bit to;
        for (int i = 0; i < NUM_LIMBS; i++) stim[i] = 17'h1FFFF;
        out_ready = 1'b1;
        push_model();
        accept_product(to);
        if (!to) wait_idle(200, to);
        total++;
        if (to) begin bad++; $display("FAIL all_max_done actual=timeout required=drained"); end
    endtask

    task automatic test_stall();
        bit to;
        int k;
        logic pstall;
        logic [WL+IDX_W+CARRY_W:0] snap;
        for (int i = 0; i < NUM_LIMBS; i++) stim[i] = 17'h0FFFF;
        push_model();
        beats = 0;
        out_ready = 1'b1;
        accept_product(to);
        total++;
        if (to) begin bad++; $display("FAIL stall_accept actual=timeout required=accepted"); end
        k = 0;
        pstall = 1'b0;
        snap = '0;
        while ((busy || q.size() != 0) && k < 400) begin
            out_ready = (k % 4 == 0) || (k % 4 == 3);
            in_valid  = busy && ($urandom_range(0, 1) == 1);
            if (in_valid) for (int i = 0; i < NUM_LIMBS; i++) stim[i] = 17'($urandom);
            @(negedge clk);
            if (pstall) begin
                total++;
                if ({out_valid, out_word, out_idx, out_last, out_carry} !== {1'b1, snap}) begin
                    bad++;
                    $display("FAIL stall_hold actual=%h required=%h", {out_valid, out_word, out_idx, out_last, out_carry}, {1'b1, snap});
                end
            end
            if (busy) begin
                total++;
                if (in_ready !== 1'b0) begin bad++; $display("FAIL in_ready_busy actual=%b required=0", in_ready); end
            end
            pstall = out_valid && !out_ready;
            snap   = {out_word, out_idx, out_last, out_carry};
            @(posedge clk); #1;
            k++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        total++;
        if (k >= 400) begin bad++; $display("FAIL stall_done actual=timeout required=drained"); end
        total++;
        if (beats !== NUM_LIMBS) begin bad++; $display("FAIL stall_beats actual=%0d required=%0d", beats, NUM_LIMBS); end
    endtask

    task automatic test_reset_mid_run();
        bit to;
        int n;
        stim[0] = 17'h1FFFF;
        for (int i = 1; i < NUM_LIMBS; i++) stim[i] = 17'h0FFFF;
        out_ready = 1'b1;
        push_model();
        accept_product(to);
        n = 0;
        while (!(out_valid && out_idx == IDX_W'(5)) && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 100) begin bad++; $display("FAIL reach_idx5 actual=timeout required=idx 5"); end
        rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            bad++;
            $display("FAIL async_reset valid/in_ready/busy actual=%b required=010", {out_valid, in_ready, busy});
        end
        total++;
        if ({out_word, out_idx} !== '0) begin
            bad++;
            $display("FAIL async_reset_data word=%h idx=%0d required=0", out_word, out_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        @(posedge clk); #1;
        total++;
        if ({in_ready, busy, out_valid} !== 3'b100) begin
            bad++;
            $display("FAIL after_reset in_ready/busy/valid actual=%b required=100", {in_ready, busy, out_valid});
        end
        push_model();
        accept_product(to);
        if (!to) wait_idle(200, to);
        total++;
        if (to) begin bad++; $display("FAIL restart_done actual=timeout required=drained"); end
    endtask

    task automatic test_random();
        logic [287:0] ta, tb;
        logic [PW-1:0] p;
        logic [NUM_LIMBS-1:0] bor;
        logic prev_b;
        exp_t e;
        bit to;
        int k;
        for (int v = 0; v < 1000; v++) begin
            for (int j = 0; j < 9; j++) begin
                ta[j*32 +: 32] = $urandom;
                tb[j*32 +: 32] = $urandom;
            end
            p = {272'b0, ta[271:0]} * {272'b0, tb[271:0]};
            // Split the product into redundant limbs: borrow 1 from the next word into a spill bit.
            for (int i = 0; i < NUM_LIMBS; i++) begin
                bor[i] = 1'b0;
                if (i < NUM_LIMBS - 1)
                    if (p[(i+1)*WL +: WL] != '0) bor[i] = ($urandom_range(0, 1) == 1);
            end
            prev_b = 1'b0;
            for (int i = 0; i < NUM_LIMBS; i++) begin
                stim[i] = 17'(p[i*WL +: WL]) + (bor[i] ? 17'h10000 : 17'h0) - (prev_b ? 17'd1 : 17'd0);
                prev_b  = bor[i];
                e.word  = p[i*WL +: WL];
                e.idx   = IDX_W'(i);
                e.last  = (i == NUM_LIMBS - 1);
                e.carry = '0;
                q.push_back(e);
            end
            acc = '0;
            out_ready = 1'b1;
            accept_product(to);
            k = 0;
            while (!to && (busy || q.size() != 0) && k < 400) begin
                out_ready = ($urandom_range(0, 3) != 0);
                @(posedge clk); #1;
                k++;
            end
            out_ready = 1'b1;
            total++;
            if (to || k >= 400) begin
                bad++;
                $display("FAIL random_done vec=%0d actual=timeout required=drained", v);
                q.delete();
            end
            total++;
            if (acc !== p) begin
                bad++;
                $display("FAIL random_product vec=%0d actual_lsw=%h required_lsw=%h", v, acc[63:0], p[63:0]);
            end
        end
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_all_ones();
        test_spill_lsw();
        test_all_max();
        test_stall();
        test_reset_mid_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
